// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, ALU control
// encodings and the sequencer state enum.
package alu_seq_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_SLLV = 4'd7;
    localparam logic [3:0] OP_SRLV = 4'd8;
    localparam logic [3:0] OP_SRAV = 4'd9;
    localparam logic [3:0] OP_NEG  = 4'd10;

    // alu_ctrl[2:0] selects the function; this bit picks shamt over inp2[4:0]
    localparam int CTRL_SHAMT_SEL = 3;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_NEG = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_SLL = 3'b100;
    localparam logic [2:0] FN_SRL = 3'b101;
    localparam logic [2:0] FN_SRA = 3'b110;

    localparam logic [3:0] CTRL_ADD = {1'b0, FN_ADD};
    localparam logic [3:0] CTRL_NEG = {1'b0, FN_NEG};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SUB1,
        ST_SUB2,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ALU control word plus sequencing attributes.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_ctrl,
    output logic       o_two_pass,
    output logic       o_illegal,
    output logic       o_carry_valid
);

    logic [2:0] w_fn;
    logic       w_imm;

    always_comb begin
        w_fn          = FN_ADD;
        w_imm         = 1'b0;
        o_two_pass    = 1'b0;
        o_illegal     = 1'b0;
        o_carry_valid = 1'b0;
        case (i_op)
            OP_ADD:  o_carry_valid = 1'b1;
            OP_SUB: begin
                // first pass negates B; the add pass is issued by the sequencer
                w_fn          = FN_NEG;
                o_two_pass    = 1'b1;
                o_carry_valid = 1'b1;
            end
            OP_AND:  w_fn = FN_AND;
            OP_XOR:  w_fn = FN_XOR;
            OP_SLL:  begin w_fn = FN_SLL; w_imm = 1'b1; end
            OP_SRL:  begin w_fn = FN_SRL; w_imm = 1'b1; end
            OP_SRA:  begin w_fn = FN_SRA; w_imm = 1'b1; end
            OP_SLLV: w_fn = FN_SLL;
            OP_SRLV: w_fn = FN_SRL;
            OP_SRAV: w_fn = FN_SRA;
            OP_NEG:  w_fn = FN_NEG;
            default: o_illegal = 1'b1;
        endcase
        o_ctrl                 = 4'd0;
        o_ctrl[2:0]            = w_fn;
        o_ctrl[CTRL_SHAMT_SEL] = w_imm;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side ALU controller: accepts one request, runs one or two ALU passes,
// and holds the registered result until writeback takes it.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    input  logic [4:0]  req_rd,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_neg,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_neg,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [4:0]  rsp_rd
);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_tmp;
    logic [4:0]          r_shamt;
    logic [3:0]          r_ctrl;
    logic                r_carry_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_carry;
    logic                r_rsp_neg;
    logic                r_rsp_zero;
    logic                r_rsp_err;
    logic [TAG_W-1:0]    r_rsp_rd;

    logic [3:0]          w_dec_ctrl;
    logic                w_dec_two_pass;
    logic                w_dec_illegal;
    logic                w_dec_carry_valid;
    logic                w_accept;

    alu_op_decode u_decode (
        .i_op          (req_op),
        .o_ctrl        (w_dec_ctrl),
        .o_two_pass    (w_dec_two_pass),
        .o_illegal     (w_dec_illegal),
        .o_carry_valid (w_dec_carry_valid)
    );

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_neg   = r_rsp_neg;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
    assign rsp_rd    = r_rsp_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // inp1 is always A so the captured neg/zero flags describe operand A
    always_comb begin
        w_state_next = r_state;
        alu_inp1     = '0;
        alu_inp2     = '0;
        alu_shamt    = '0;
        alu_ctrl     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_dec_illegal) begin
                        w_state_next = ST_RESP;
                    end else if (w_dec_two_pass) begin
                        w_state_next = ST_SUB1;
                    end else begin
                        w_state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                alu_inp1     = r_a;
                alu_inp2     = r_b;
                alu_shamt    = r_shamt;
                alu_ctrl     = r_ctrl;
                w_state_next = ST_RESP;
            end
            ST_SUB1: begin
                alu_inp1     = r_a;
                alu_inp2     = r_b;
                alu_shamt    = r_shamt;
                alu_ctrl     = CTRL_NEG;
                w_state_next = ST_SUB2;
            end
            ST_SUB2: begin
                alu_inp1     = r_a;
                alu_inp2     = r_tmp;
                alu_shamt    = r_shamt;
                alu_ctrl     = CTRL_ADD;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_tmp         <= '0;
            r_shamt       <= '0;
            r_ctrl        <= '0;
            r_carry_valid <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_carry   <= 1'b0;
            r_rsp_neg     <= 1'b0;
            r_rsp_zero    <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a           <= req_a;
                        r_b           <= req_b;
                        r_shamt       <= req_shamt;
                        r_ctrl        <= w_dec_ctrl;
                        r_carry_valid <= w_dec_carry_valid;
                        r_rsp_rd      <= req_rd;
                        r_rsp_err     <= w_dec_illegal;
                        if (w_dec_illegal) begin
                            r_rsp_data  <= '0;
                            r_rsp_carry <= 1'b0;
                            r_rsp_neg   <= 1'b0;
                            r_rsp_zero  <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_carry <= alu_carry && r_carry_valid;
                    r_rsp_neg   <= alu_neg;
                    r_rsp_zero  <= alu_zero;
                end
                ST_SUB1: begin
                    r_tmp <= alu_out;
                end
                ST_SUB2: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_carry <= alu_carry;
                    r_rsp_neg   <= alu_neg;
                    r_rsp_zero  <= alu_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a behavioural ALU
// attached to its ALU port and a separate response monitor.
module tb_alu_op_sequencer;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] data;
        logic        carry;
        logic        neg;
        logic        zero;
        logic        err;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [4:0]  req_rd;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_neg;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_neg;
    logic        rsp_zero;
    logic        rsp_err;
    logic [4:0]  rsp_rd;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t q[$];
    bit   in_resp     = 0;
    bit   expect_idle = 0;
    int   bp_hold     = 0;
    int   hold        = 0;
    exp_t cur;
    logic [31:0] snap_data;
    logic [9:0]  snap_misc;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .req_rd    (req_rd),
        .alu_inp1  (alu_inp1),
        .alu_inp2  (alu_inp2),
        .alu_shamt (alu_shamt),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_neg   (rsp_neg),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .rsp_rd    (rsp_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: flags describe inp1, SRA is arithmetic
    logic [4:0]  m_sh;
    logic [32:0] m_sum;
    always_comb begin
        m_sh      = alu_ctrl[3] ? alu_shamt : alu_inp2[4:0];
        m_sum     = {1'b0, alu_inp1} + {1'b0, alu_inp2};
        alu_out   = 32'd0;
        alu_carry = 1'b0;
        case (alu_ctrl[2:0])
            3'd0: begin alu_out = m_sum[31:0]; alu_carry = m_sum[32]; end
            3'd1: alu_out = 32'd0 - alu_inp2;
            3'd2: alu_out = alu_inp1 & alu_inp2;
            3'd3: alu_out = alu_inp1 ^ alu_inp2;
            3'd4: alu_out = alu_inp1 << m_sh;
            3'd5: alu_out = alu_inp1 >> m_sh;
            3'd6: alu_out = $signed(alu_inp1) >>> m_sh;
            default: alu_out = 32'd0;
        endcase
        alu_neg  = alu_inp1[31];
        alu_zero = (alu_inp1 == 32'd0);
    end

    function automatic exp_t ref_resp(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh,
                                      input logic [4:0] rd);
        exp_t e;
        logic [32:0] s;
        logic signed [31:0] sa;
        sa = a;
        e.op = op; e.data = 32'd0; e.carry = 1'b0; e.neg = a[31];
        e.zero = (a == 32'd0); e.err = 1'b0; e.rd = rd; e.lat = 1; e.acc = 0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[31:0]; e.carry = s[32]; end
            4'd1: begin
                s = {1'b0, a} + {1'b0, 32'd0 - b};
                e.data = a - b; e.carry = s[32]; e.lat = 2;
            end
            4'd2:  e.data = a & b;
            4'd3:  e.data = a ^ b;
            4'd4:  e.data = a << sh;
            4'd5:  e.data = a >> sh;
            4'd6:  e.data = sa >>> sh;
            4'd7:  e.data = a << b[4:0];
            4'd8:  e.data = a >> b[4:0];
            4'd9:  e.data = sa >>> b[4:0];
            4'd10: e.data = 32'd0 - b;
            default: begin e.err = 1'b1; e.neg = 1'b0; e.zero = 1'b0; e.lat = 0; end
        endcase
        return e;
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'd0:  return 4'b0000;
            4'd1:  return 4'b0001;
            4'd2:  return 4'b0010;
            4'd3:  return 4'b0011;
            4'd4:  return 4'b1100;
            4'd5:  return 4'b1101;
            4'd6:  return 4'b1110;
            4'd7:  return 4'b0100;
            4'd8:  return 4'b0101;
            4'd9:  return 4'b0110;
            4'd10: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on each new response, then checks stability
    always @(negedge clk) begin
        if (rst) begin
            in_resp     = 0;
            expect_idle = 0;
            hold        = 0;
            rsp_ready   = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("valid_low_after_hs", 32'(rsp_valid), 32'd0);
                chk("ready_after_hs", 32'(req_ready), 32'd1);
                expect_idle = 0;
            end
            if (rsp_valid) begin
                chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        cur = q.pop_front();
                        $display("rsp op=%0d rd=%0d data=0x%08h c=%0b n=%0b z=%0b err=%0b lat=%0d",
                                 cur.op, rsp_rd, rsp_data, rsp_carry, rsp_neg, rsp_zero,
                                 rsp_err, cyc - cur.acc);
                        chk("rsp_data", rsp_data, cur.data);
                        chk("rsp_flags_cnze", 32'({rsp_carry, rsp_neg, rsp_zero, rsp_err}),
                            32'({cur.carry, cur.neg, cur.zero, cur.err}));
                        chk("rsp_rd", 32'(rsp_rd), 32'(cur.rd));
                        chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                    snap_data = rsp_data;
                    snap_misc = {rsp_carry, rsp_neg, rsp_zero, rsp_err, rsp_rd, 1'b0};
                    in_resp   = 1;
                    hold      = bp_hold;
                    bp_hold   = 0;
                end else begin
                    chk("rsp_stable_data", rsp_data, snap_data);
                    chk("rsp_stable_misc",
                        32'({rsp_carry, rsp_neg, rsp_zero, rsp_err, rsp_rd, 1'b0}),
                        32'(snap_misc));
                end
                if (hold > 0) begin
                    rsp_ready = 1'b0;
                    hold--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) begin
                    in_resp     = 0;
                    expect_idle = 1;
                end
            end else begin
                if (in_resp) begin
                    fail_now("rsp_valid_dropped_early");
                    in_resp = 0;
                end
                rsp_ready = 1'b0;
                if (q.size() > 0 && (cyc - q[0].acc) > 60) begin
                    fail_now("response_timeout");
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] rd);
        exp_t e;
        int   waited = 0;
        req_op = op; req_a = a; req_b = b; req_shamt = sh; req_rd = rd;
        req_valid = 1'b1;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            fail_now("req_accept_wait");
            req_valid = 1'b0;
            return;
        end
        e     = ref_resp(op, a, b, sh, rd);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("alu_ctrl_pass1", 32'(alu_ctrl), 32'(ref_ctrl(op)));
        if (op == 4'd1) begin
            @(negedge clk);
            chk("alu_ctrl_pass2", 32'(alu_ctrl), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((q.size() != 0 || in_resp || rsp_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) fail_now("wait_idle");
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] op;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        req_shamt = 5'd0; req_rd = 5'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_misc", 32'({rsp_carry, rsp_neg, rsp_zero, rsp_err, rsp_rd}), 32'd0);
        chk("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("reset_alu_inp", alu_inp1 | alu_inp2 | 32'(alu_shamt), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd1);
        send(4'd1, 32'd5, 32'd7, 5'd0, 5'd2);
        send(4'd6, 32'h8000_0000, 32'd0, 5'd4, 5'd3);
        send(4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 5'd9);

        // Backpressure: second request waits while the AND response is held
        wait_idle();
        bp_hold = 5;
        send(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 5'd4);
        send(4'd0, 32'd100, 32'd23, 5'd0, 5'd5);

        // Reset pulsed while the SUB is on its add pass
        wait_idle();
        send(4'd1, 32'd50, 32'd8, 5'd0, 5'd6);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(req_ready), 32'd1);
        chk("midrst_valid_after", 32'(rsp_valid), 32'd0);
        send(4'd0, 32'd2, 32'd3, 5'd0, 5'd7);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(11, 15));
            else op = 4'($urandom_range(0, 10));
            bp_hold = $urandom_range(0, 3);
            send(op, rand_word(), rand_word(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
